// File: rtl/cmt_pkg.sv
// Shared field types, default field constants, sumcheck FSM states and modular add/sub helpers.
package cmt_pkg;

    typedef logic [31:0] uint_t;

    localparam uint_t CMT_PRIME = 32'd2147483647;
    localparam uint_t CMT_INV2  = 32'd1073741824;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_PTS = 3'd1,
        S_CHECK    = 3'd2,
        S_SAMPLE   = 3'd3,
        S_EVAL     = 3'd4,
        S_NEXT     = 3'd5,
        S_DONE     = 3'd6
    } sc_state_e;

    // Operands must be below p; one conditional subtract restores the range.
    function automatic uint_t mod_add(input uint_t a, input uint_t b, input uint_t p);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, p}) begin
            s = s - {1'b0, p};
        end else begin
            s = s;
        end
        return s[31:0];
    endfunction

    function automatic uint_t mod_sub(input uint_t a, input uint_t b, input uint_t p);
        uint_t r;
        if (a >= b) begin
            r = a - b;
        end else begin
            r = a - b + p;
        end
        return r;
    endfunction

endpackage

// File: rtl/mod_mul.sv
// Serial MSB-first shift-add modular multiplier; result appears W+1 cycles after start.
module mod_mul
    import cmt_pkg::*;
#(
    parameter int          W     = 32,
    parameter int unsigned PRIME = CMT_PRIME
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         start_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] result_o
);
    localparam uint_t P32 = uint_t'(PRIME);
    localparam int    CW  = $clog2(W + 1);

    logic [W-1:0]  a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic [W-1:0]  dbl_s, step_s;

    assign dbl_s  = W'(mod_add(uint_t'(acc_q), uint_t'(acc_q), P32));
    assign step_s = b_q[W-1] ? W'(mod_add(uint_t'(dbl_s), uint_t'(a_q), P32)) : dbl_s;

    // Next-state: load on start, then one multiplier bit per cycle.
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (busy_q) begin
            acc_d = step_s;
            b_d   = {b_q[W-2:0], 1'b0};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                busy_d = 1'b1;
            end
        end else if (start_i) begin
            a_d    = a_i;
            b_d    = b_i;
            acc_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else begin
            busy_d = 1'b0;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = acc_q;

endmodule

// File: rtl/sumcheck_round_verifier.sv
// Verifier-side sumcheck engine for one layer: sum check, serial challenge, degree-2 interpolation.
// Optional macro SUMCHECK_EARLY_ABORT_EN: a failed round check ends the layer immediately.
module sumcheck_round_verifier
    import cmt_pkg::*;
#(
    parameter int          UINT_WIDTH = 32,
    parameter int          NUM_LAYERS = 4,
    parameter int          NUM_BITS   = NUM_LAYERS - 1,
    parameter int          NUM_ROUNDS = 2 * NUM_BITS,
    parameter int unsigned PRIME      = CMT_PRIME,
    parameter int          R_BITS     = 31,
    localparam int         RW         = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       start,
    input  logic [UINT_WIDTH-1:0]      claim,
    input  logic [NUM_LAYERS-1:0]      layer_idx,
    input  logic                       random,
    input  logic [2:0][UINT_WIDTH-1:0] sample_pts,
    input  logic                       pts_valid,
    output logic                       pts_ready,
    output logic [UINT_WIDTH-1:0]      r_out,
    output logic                       r_valid,
    output logic [RW-1:0]              r_round,
    output logic [NUM_LAYERS-1:0]      r_layer,
    output logic [UINT_WIDTH-1:0]      final_claim,
    output logic                       done,
    output logic                       accept
);
    localparam int BC = $clog2(R_BITS + 1);
    typedef logic [UINT_WIDTH-1:0] fe_t;
    localparam uint_t P32     = uint_t'(PRIME);
    localparam fe_t   P_FE    = fe_t'(P32);
    localparam fe_t   INV2_FE = fe_t'((P32 + 32'd1) >> 1);

    function automatic fe_t fadd(input fe_t a, input fe_t b);
        return fe_t'(mod_add(uint_t'(a), uint_t'(b), P32));
    endfunction

    function automatic fe_t fsub(input fe_t a, input fe_t b);
        return fe_t'(mod_sub(uint_t'(a), uint_t'(b), P32));
    endfunction

    sc_state_e             state_q, state_d;
    fe_t                   claim_q, claim_d, g0_q, g0_d, g1_q, g1_d, g2_q, g2_d;
    fe_t                   r_q, r_d, prod_t_q, prod_t_d, prod_a_q, prod_a_d;
    fe_t                   gr_q, gr_d, final_q, final_d;
    logic [NUM_LAYERS-1:0] layer_q, layer_d;
    logic [RW-1:0]         round_q, round_d;
    logic [BC-1:0]         bit_cnt_q, bit_cnt_d;
    logic [1:0]            phase_q, phase_d, sel_s;
    logic                  accept_q, accept_d, issue_q, issue_d;
    logic                  mul_start_s, mul_done_s, check_fail_s;
    fe_t                   mul_a_s, mul_b_s, mul_res_s, d1_s, d2_s, r_m1_s, r_shift_s, r_red_s;

    assign check_fail_s = (g0_q >= P_FE) || (g1_q >= P_FE) || (g2_q >= P_FE)
                        || (fadd(g0_q, g1_q) != claim_q);
    assign d1_s      = fsub(g1_q, g0_q);
    assign d2_s      = fsub(fadd(g2_q, g0_q), fadd(g1_q, g1_q));
    assign r_m1_s    = fsub(r_q, fe_t'(1'b1));
    assign r_shift_s = {r_q[UINT_WIDTH-2:0], random};
    assign r_red_s   = (r_shift_s >= P_FE) ? (r_shift_s - P_FE) : r_shift_s;
    assign sel_s     = issue_q ? 2'd0 : (phase_q + 2'd1);

    mod_mul #(.W(UINT_WIDTH), .PRIME(PRIME)) u_mul (
        .clk      (clk),
        .nrst     (nrst),
        .start_i  (mul_start_s),
        .a_i      (mul_a_s),
        .b_i      (mul_b_s),
        .busy_o   (),
        .done_o   (mul_done_s),
        .result_o (mul_res_s)
    );

    // Next-state and datapath control for the round sequence.
    always_comb begin
        state_d = state_q;    claim_d  = claim_q;  g0_d      = g0_q;     g1_d     = g1_q;
        g2_d    = g2_q;       r_d      = r_q;      prod_t_d  = prod_t_q; prod_a_d = prod_a_q;
        gr_d    = gr_q;       final_d  = final_q;  layer_d   = layer_q;  round_d  = round_q;
        phase_d = phase_q;    accept_d = accept_q; bit_cnt_d = bit_cnt_q;
        issue_d = 1'b0;       mul_start_s = 1'b0;
        // Operand schedule: r*(r-1), t*INV2, r*d1, t*d2; each start overlaps the previous done.
        case (sel_s)
            2'd0:    begin mul_a_s = r_q;       mul_b_s = r_m1_s;  end
            2'd1:    begin mul_a_s = mul_res_s; mul_b_s = INV2_FE; end
            2'd2:    begin mul_a_s = r_q;       mul_b_s = d1_s;    end
            default: begin mul_a_s = prod_t_q;  mul_b_s = d2_s;    end
        endcase
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    claim_d  = claim;
                    layer_d  = layer_idx;
                    accept_d = 1'b1;
                    round_d  = '0;
                    state_d  = S_WAIT_PTS;
                end else begin
                    state_d = state_q;
                end
            end
            S_WAIT_PTS: begin
                if (pts_valid) begin
                    g0_d    = sample_pts[0];
                    g1_d    = sample_pts[1];
                    g2_d    = sample_pts[2];
                    state_d = S_CHECK;
                end else begin
                    state_d = S_WAIT_PTS;
                end
            end
            S_CHECK: begin
                r_d       = '0;
                bit_cnt_d = '0;
`ifdef SUMCHECK_EARLY_ABORT_EN
                if (check_fail_s) begin
                    accept_d = 1'b0;
                    final_d  = '0;
                    state_d  = S_DONE;
                end else begin
                    state_d = S_SAMPLE;
                end
`else
                if (check_fail_s) begin
                    accept_d = 1'b0;
                end else begin
                    accept_d = accept_q;
                end
                state_d = S_SAMPLE;
`endif
            end
            S_SAMPLE: begin
                r_d       = r_shift_s;
                bit_cnt_d = bit_cnt_q + BC'(1);
                if (bit_cnt_q == BC'(R_BITS - 1)) begin
                    r_d     = r_red_s;
                    phase_d = 2'd0;
                    issue_d = 1'b1;
                    state_d = S_EVAL;
                end else begin
                    state_d = S_SAMPLE;
                end
            end
            S_EVAL: begin
                mul_start_s = issue_q || (mul_done_s && (phase_q != 2'd3));
                if (mul_done_s) begin
                    case (phase_q)
                        2'd1:    prod_t_d = mul_res_s;
                        2'd2:    prod_a_d = mul_res_s;
                        2'd3: begin
                            gr_d    = fadd(fadd(g0_q, prod_a_q), mul_res_s);
                            state_d = S_NEXT;
                        end
                        default: prod_t_d = prod_t_q;
                    endcase
                    phase_d = (phase_q == 2'd3) ? phase_q : (phase_q + 2'd1);
                end else begin
                    phase_d = phase_q;
                end
            end
            S_NEXT: begin
                claim_d = gr_q;
                if (round_q == RW'(NUM_ROUNDS - 1)) begin
                    final_d = gr_q;
                    state_d = S_DONE;
                end else begin
                    round_d = round_q + RW'(1);
                    state_d = S_WAIT_PTS;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= S_IDLE;  claim_q  <= '0;   g0_q      <= '0; g1_q     <= '0;
            g2_q    <= '0;      r_q      <= '0;   prod_t_q  <= '0; prod_a_q <= '0;
            gr_q    <= '0;      final_q  <= '0;   layer_q   <= '0; round_q  <= '0;
            phase_q <= '0;      accept_q <= 1'b1; bit_cnt_q <= '0; issue_q  <= 1'b0;
        end else begin
            state_q <= state_d; claim_q  <= claim_d;  g0_q      <= g0_d;      g1_q     <= g1_d;
            g2_q    <= g2_d;    r_q      <= r_d;      prod_t_q  <= prod_t_d;  prod_a_q <= prod_a_d;
            gr_q    <= gr_d;    final_q  <= final_d;  layer_q   <= layer_d;   round_q  <= round_d;
            phase_q <= phase_d; accept_q <= accept_d; bit_cnt_q <= bit_cnt_d; issue_q  <= issue_d;
        end
    end

    assign pts_ready   = (state_q == S_WAIT_PTS);
    assign r_valid     = (state_q == S_NEXT);
    assign done        = (state_q == S_DONE);
    assign r_out       = r_q;
    assign r_round     = round_q;
    assign r_layer     = layer_q;
    assign final_claim = final_q;
    assign accept      = accept_q;

endmodule

// File: doc/sumcheck_round_verifier.md
Name: sumcheck_round_verifier

Overview:
- Verifier-side sumcheck engine for one CMT layer, instantiated under the layer verifier.
- Takes the layer's current claim and runs NUM_ROUNDS sumcheck rounds. Each round it takes three prover evaluations g(0), g(1), g(2), checks g(0)+g(1) == claim mod PRIME, samples a serial random field element r, and computes the next claim g(r) by degree-2 interpolation.
- Emits the per-round random points and the final reduced claim, plus a sticky accept.

Parameters:
- UINT_WIDTH, 32, field element width.
- NUM_LAYERS, 4, circuit depth; sets the width of layer_idx.
- NUM_BITS, NUM_LAYERS-1, gate-index bits per layer.
- NUM_ROUNDS, 2*NUM_BITS, sumcheck rounds per layer.
- PRIME, 2147483647, field modulus; must be < 2^UINT_WIDTH.
- R_BITS, 31, random bits shifted in per challenge; must satisfy 2^R_BITS < 2*PRIME.

Ports:
- clk, input, 1, clock.
- nrst, input, 1, synchronous active-low reset.
- start, input, 1, pulse; latches claim and begins a layer.
- claim, input, UINT_WIDTH, initial claim (curr_result of the layer).
- layer_idx, input, NUM_LAYERS, layer tag; latched at start and echoed on r_layer.
- random, input, 1, serial random bit, MSB first.
- sample_pts, input, 3 x UINT_WIDTH, g(0), g(1), g(2).
- pts_valid, input, 1, sample_pts valid.
- pts_ready, output, 1, engine can accept points.
- r_out, output, UINT_WIDTH, challenge of the round just finished.
- r_valid, output, 1, one-cycle strobe with r_out.
- r_round, output, clog2(NUM_ROUNDS), round index of r_out.
- r_layer, output, NUM_LAYERS, latched layer_idx.
- final_claim, output, UINT_WIDTH, g(r) of the last round; valid while done.
- done, output, 1, high in DONE.
- accept, output, 1, sticky verdict.

Behaviour:
- Reset state:
  - State is IDLE.
  - All outputs are 0, except accept = 1.
  - nrst low in any state, including mid-multiply, aborts to IDLE and clears the round counter.
- IDLE:
  - On start: latch claim and layer_idx, set accept = 1, round = 0, go to WAIT_PTS.
  - start is ignored in every other state except DONE.
- WAIT_PTS:
  - pts_ready = 1.
  - When pts_valid && pts_ready: latch the points and go to CHECK.
  - pts_ready drops the following cycle.
- CHECK (1 cycle):
  - accept <= 0 if any point >= PRIME, or if (g0+g1) mod PRIME != claim.
  - The sum is computed at UINT_WIDTH+1 bits with one conditional subtract.
  - The round always continues; failure is sticky.
- SAMPLE (exactly R_BITS cycles):
  - Shift: r <= {r, random}.
  - On exit: if r >= PRIME, subtract PRIME once.
- EVAL:
  - Form d1 = g1-g0 and d2 = g2-2*g1+g0, each mod PRIME.
  - Issue four modular multiplies sequentially on a shared multiplier:
    - t = r*(r-1)
    - t = t*INV2, where INV2 = (PRIME+1)/2
    - a = r*d1
    - b = t*d2
  - Each multiply takes UINT_WIDTH+1 cycles.
  - One final cycle computes g(r) = g0+a+b mod PRIME.
  - All add/sub results are kept in [0, PRIME).
- NEXT (1 cycle):
  - claim <= g(r); pulse r_valid with r_out = r and r_round = round.
  - If round == NUM_ROUNDS-1: final_claim <= g(r), go to DONE.
  - Else: round++, go to WAIT_PTS.
- DONE:
  - done = 1; final_claim and accept are held.
  - start here begins a new layer in the same cycle as IDLE would.
- Per-round latency after the handshake: 1 + R_BITS + 4*(UINT_WIDTH+1) + 1 + 1 cycles.

Optional Feature:
- Macro: SUMCHECK_EARLY_ABORT_EN.
- Defined: a failed CHECK goes straight to DONE with accept = 0 and final_claim = 0; the remaining rounds are skipped and no further r_valid is issued.
- Undefined: all NUM_ROUNDS rounds always run. Timing is constant regardless of the verdict.

Decomposition:
- Package cmt_pkg:
  - uint_t typedef;
  - PRIME and INV2 constants;
  - sumcheck state enum (IDLE, WAIT_PTS, CHECK, SAMPLE, EVAL, NEXT, DONE);
  - mod_add / mod_sub functions.
- Sub-module mod_mul:
  - Serial shift-add modular multiplier with start/busy/done handshake.
  - Fixed latency of UINT_WIDTH+1 cycles; interleaved conditional subtract keeps partials < PRIME.

Test Plan:
All scenarios use UINT_WIDTH=8, PRIME=97, R_BITS=7, NUM_BITS=1 (NUM_ROUNDS=2).
- Honest round: claim=10, pts=(3,7,15), random bits = 5 -> r_valid with r_out=5, next claim 63, accept stays 1.
- Bad sum: claim=11, pts=(3,7,15) -> accept=0 after CHECK, both rounds still complete, done=1.
- Wrap: claim=10, pts=(90,17,0) -> (90+17) mod 97 = 10, accept=1. Random bits giving 100 -> r_out=3.
- Out-of-range point: pts=(3,7,97) -> accept=0.
- Two rounds, with a second round consistent with 63 -> done after round 1, final_claim correct, r_round sequence 0,1.
- nrst low mid-EVAL -> IDLE, all outputs reset. A subsequent start completes normally.
